// File: rtl/util_pkg.sv
// ============================================================================
// util_pkg -- shared constants for the BCD conversion path
// Rev 1.0
// ============================================================================
`default_nettype none

package util_pkg;

  localparam logic [1:0]  S_IDLE          = 2'd0;
  localparam logic [1:0]  S_SHIFT         = 2'd1;
  localparam logic [1:0]  S_LOAD          = 2'd2;

  localparam int          BCD_DIGITS      = 4;
  localparam logic [15:0] BCD_MAX         = 16'd9999;
  localparam logic [15:0] BCD_OVF_PATTERN = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/bcd_adj3.sv
// ============================================================================
// bcd_adj3 -- single-digit add-3 correction applied before each shift
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_adj3 (
  input  logic [3:0] in,
  output logic [3:0] out
);

  assign out = (in >= 4'd5) ? (in + 4'd3) : in;

endmodule

`default_nettype wire

// File: rtl/bcd_conv.sv
// ============================================================================
// bcd_conv -- sequential binary to 4-digit packed BCD, one input bit per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_conv
  import util_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd,
  output logic         ovf
);

  localparam int             CW         = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  c_cnt_init = CW'(W - 1);

  logic [1:0]    r_state;
  logic [W-1:0]  r_sr;
  logic [15:0]   r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_ovf_pend;

  logic [15:0]   w_adj;
  logic [15:0]   w_bin_ext;
  logic [15+W:0] w_next;

  genvar g;
  generate
    for (g = 0; g < BCD_DIGITS; g++) begin : g_adj
      bcd_adj3 u_adj (
        .in  (r_acc[4*g +: 4]),
        .out (w_adj[4*g +: 4])
      );
    end
  endgenerate

  assign w_bin_ext = 16'(bin);
  // Adjusted digits and remaining input bits shift together as one register.
  assign w_next    = {w_adj, r_sr} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sr       <= bin;
            r_acc      <= '0;
            r_ovf_pend <= (w_bin_ext > BCD_MAX);
            r_cnt      <= c_cnt_init;
            busy       <= 1'b1;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc <= w_next[15+W:W];
          r_sr  <= w_next[W-1:0];
          if (r_cnt == '0) begin
            r_state <= S_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_LOAD: begin
          bcd     <= r_ovf_pend ? BCD_OVF_PATTERN : r_acc;
          ovf     <= r_ovf_pend;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv.sv
// ============================================================================
// tb_bcd_conv -- directed checks of bcd_conv at W=14 and W=4
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        busy, done, ovf;
  logic [15:0] bcd;

  logic        start4;
  logic [3:0]  bin4;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  bcd_conv #(.W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bcd_conv #(.W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bin(bin4),
    .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for done with a cycle budget; returns cycles since the accept edge
  // and how many of those samples showed busy high.
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bc++;
      tick();
      lat++;
    end
  endtask

  task automatic conv14(input logic [13:0] b, input logic [15:0] exp_bcd,
                        input logic exp_ovf, input string tag);
    int lat, bc;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    bin   = 14'($urandom);
    wait_done(lat, bc);
    check({tag, "_lat"},  lat, 15);
    check({tag, "_busyc"}, bc, 15);
    check({tag, "_bcd"},  bcd, exp_bcd);
    check({tag, "_ovf"},  ovf, exp_ovf);
    check({tag, "_busy"}, busy, 0);
    tick();
    check({tag, "_done1"}, done, 0);
  endtask

  initial begin
    int lat, bc, seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin    = '0;
    start4 = 1'b0;
    bin4   = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd",  bcd, 16'h0000);
    check("rst_ovf",  ovf, 0);
    rst_n = 1'b1;
    tick();

    conv14(14'd0, 16'h0000, 1'b0, "zero");

    // Back-to-back: start held high through the first done
    start = 1'b1;
    bin   = 14'd1234;
    tick();
    bin   = 14'd9999;
    wait_done(lat, bc);
    check("b2b1_lat", lat, 15);
    check("b2b1_bcd", bcd, 16'h1234);
    tick();
    start = 1'b0;
    check("b2b_accept", busy, 1);
    check("b2b_pulse",  done, 0);
    wait_done(lat, bc);
    check("b2b2_lat", lat, 15);
    check("b2b2_bcd", bcd, 16'h9999);
    check("b2b2_ovf", ovf, 0);
    tick();

    conv14(14'd10000, 16'hFFFF, 1'b1, "ovf10000");
    conv14(14'd16383, 16'hFFFF, 1'b1, "ovf16383");
    conv14(14'd42,    16'h0042, 1'b0, "after_ovf");

    // start during busy is ignored
    start = 1'b1;
    bin   = 14'd500;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    bin   = 14'd77;
    tick();
    start = 1'b0;
    lat = 5;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    check("ign_lat", lat, 15);
    check("ign_bcd", bcd, 16'h0500);
    seen = 0;
    repeat (20) begin
      tick();
      if (busy === 1'b1 || done === 1'b1) seen++;
    end
    check("ign_nosecond", seen, 0);
    check("ign_hold", bcd, 16'h0500);

    // Reset mid-conversion
    conv14(14'd1234, 16'h1234, 1'b0, "pre_rst");
    start = 1'b1;
    bin   = 14'd8765;
    tick();
    start = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("abort_bcd",  bcd, 16'h0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (done === 1'b1) seen++;
    end
    check("abort_nodone", seen, 0);
    check("abort_bcd_hold", bcd, 16'h0000);
    conv14(14'd8765, 16'h8765, 1'b0, "post_rst");

    // W=4 instance, exhaustive
    for (int b = 0; b < 16; b++) begin
      start4 = 1'b1;
      bin4   = 4'(b);
      tick();
      start4 = 1'b0;
      lat = 0;
      while (done4 !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      check($sformatf("w4_lat_%0d", b), lat, 5);
      check($sformatf("w4_bcd_%0d", b), bcd4, 32'(((b / 10) << 4) | (b % 10)));
      check($sformatf("w4_ovf_%0d", b), ovf4, 0);
      tick();
    end
    check("w4_final15", bcd4, 16'h0015);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
